// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ready + rvalid handshake,
// presents one instruction at a time. Optional INSTRET_COUNT_EN adds a retired-instruction counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic [2:0]  B_Target,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_fault
`ifdef INSTRET_COUNT_EN
  , output logic [63:0] instret
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, FAULT} state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic        sel_illegal;
  logic        target_bad;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    next_pc     = pc_plus4;
    sel_illegal = 1'b0;
    case (B_Target)
      3'b100:  next_pc = pc_plus4;
      3'b010:  next_pc = pc + imm;
      3'b001:  next_pc = {jalr_target[31:1], 1'b0};
      default: sel_illegal = 1'b1;
    endcase
  end

  // A jalr target with bit 1 set survives the bit-0 clear and faults here.
  assign target_bad = sel_illegal || (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_fault <= 1'b0;
`ifdef INSTRET_COUNT_EN
      instret     <= 64'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            imem_req <= 1'b0;
            if (imem_rvalid) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= EXEC;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            if (target_bad) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= REQ;
`ifdef INSTRET_COUNT_EN
              instret  <= instret + 64'd1;
`endif
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
